evm_vote_controller: RTL and testbench
======================================

Name: evm_vote_controller

Overview:
- Front end of the EVM. Debounces the operator buttons and the four candidate buttons, runs the election state machine, and tallies votes per candidate.
- Drives the display driver's inputs: state, tens, ones, winner.
- Sits between the board buttons and the 7-segment display block. All outputs are registered.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, stable-input cycles required before a button edge is accepted (10 ms at 100 MHz).
- MAX_VOTES, 19, cap on total votes per election. Must be ≤19 so the 1-bit tens output suffices.
- ACK_CYCLES, 50_000_000, length of the vote_ack pulse (used only with the optional feature).

Ports:
- clk_100MHz  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_open  input  1  raw button: open a new election
- btn_close  input  1  raw button: close voting
- btn_result  input  1  raw button: show winner
- vote_btn  input  4  raw candidate buttons; bit i = candidate i
- state  output  2  00 IDLE, 01 OPEN, 10 CLOSED, 11 WINNER
- tens  output  1  BCD tens digit of the displayed count (0/1)
- ones  output  4  BCD ones digit of the displayed count (0–9)
- winner  output  2  winning candidate index
- vote_ack  output  1  present only when EVM_VOTE_ACK_EN is defined

Behaviour:
- Reset (async, active-high): state=00, tens=0, ones=0, winner=00.
  - All four candidate counters, the total counter and the debounce counters clear.
  - Synchronizer flops clear to 0.
  - Takes effect immediately, including mid-vote or mid-debounce.
- Input conditioning, per button (7 total):
  - 2-flop synchronizer, then debounce.
  - The stable level updates only after the synced input differs from it for DEBOUNCE_CYCLES consecutive cycles; the counter restarts on any bounce.
  - Rising edge of the stable level gives a one-cycle press pulse.
  - Latency from raw press to pulse = DEBOUNCE_CYCLES + 3 cycles.
- FSM transitions (on press pulses, checked in the same cycle):
  - IDLE + open -> OPEN. All counters clear on entry.
  - OPEN + close -> CLOSED.
  - CLOSED + result -> WINNER. The winner register is loaded on this transition.
  - WINNER + open -> OPEN. Counters clear; this is a new election.
  - All other button/state combinations are ignored. There is no path back to IDLE except reset.
- Vote acceptance:
  - Only in OPEN.
  - Exactly one candidate press pulse must occur in the cycle; two or more simultaneous pulses are all rejected.
  - total < MAX_VOTES is required; once total = MAX_VOTES, further votes are ignored and no counter wraps.
  - An accepted vote increments cand_cnt[i] and total by 1 in the same cycle.
  - A close pulse and a vote pulse in the same cycle: the vote is accepted, then the state moves to CLOSED.
- Winner selection:
  - Winner is the candidate with the maximum count.
  - Ties resolve to the lowest index.
  - All-zero counts give winner = 00.
  - Winner holds until the next entry to OPEN or reset.
- Display value, registered one cycle after the underlying counter or state changes:
  - IDLE: 0.
  - OPEN/CLOSED: total.
  - WINNER: cand_cnt[winner].
  - Conversion: tens = (value ≥ 10); ones = value − 10·tens. Counters are 5 bits wide.

Optional Feature:
- Macro: EVM_VOTE_ACK_EN.
- When defined:
  - Port vote_ack exists.
  - vote_ack rises the cycle after an accepted vote and stays high for ACK_CYCLES cycles.
  - While vote_ack is high, all candidate presses are rejected (anti-double-vote lockout).
  - Reset or leaving OPEN clears vote_ack and the lockout counter immediately.
- When undefined:
  - No port and no lockout.
  - A vote may be accepted on every press pulse.

Test Plan (sim with DEBOUNCE_CYCLES=4, ACK_CYCLES=8):
- Reset released, no buttons -> state=00, tens=0, ones=0, winner=00. Votes pressed in IDLE -> outputs unchanged.
- open; votes c1,c1,c2,c0,c1 (clean presses) -> state=01, tens=0, ones=5. Then close, result -> state=11, winner=01, tens=0, ones=3.
- In OPEN, 25 presses on c3 -> tens=1, ones=9, no wrap. Then close + result -> winner=11, display shows 19.
- c0 and c2 pressed in the same cycle -> no change. Then the tie case: c0×2, c2×2, result -> winner=00, display 2.
- Bouncy c1 press (toggling every 2 cycles for 20 cycles, then stable high) -> exactly one vote counted. Reset asserted mid-debounce -> all outputs 0 next cycle.
- EVM_VOTE_ACK_EN defined: c0 pressed twice, 5 cycles apart after debounce -> ones=1 and vote_ack high for 8 cycles. A press after the ack drops -> ones=2.

Source files
------------

// File: rtl/evm_vote_controller.sv
// evm_vote_controller: EVM front end. Conditions the seven raw buttons
// (2-flop synchronizer + debounce + rising-edge pulse), runs the election
// FSM, tallies per-candidate votes and registers the display inputs
// (state, tens, ones, winner).
// Optional feature macro: EVM_VOTE_ACK_EN adds the vote_ack output and an
// anti-double-vote lockout while vote_ack is high.
`timescale 1ns/1ps

module evm_vote_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MAX_VOTES       = 19,
  parameter int ACK_CYCLES      = 50_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_open,
  input  logic       btn_close,
  input  logic       btn_result,
  input  logic [3:0] vote_btn,
  output logic [1:0] state,
  output logic       tens,
  output logic [3:0] ones,
  output logic [1:0] winner
`ifdef EVM_VOTE_ACK_EN
  ,
  output logic       vote_ack
`endif
);

  localparam int NBTN = 7;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] VOTE_CAP = 5'(MAX_VOTES);

  // Counters are 5 bits and tens is a single bit, so the cap cannot exceed 19.
  if (MAX_VOTES < 1 || MAX_VOTES > 19 || DEBOUNCE_CYCLES < 1 || ACK_CYCLES < 1) begin : g_bad_param
    $error("evm_vote_controller: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_OPEN   = 2'b01,
    S_CLOSED = 2'b10,
    S_WINNER = 2'b11
  } state_t;

  // Binary value 0..19 to {tens, ones}.
  function automatic logic [4:0] to_bcd(input logic [4:0] v);
    logic       t;
    logic [3:0] o;
    t = (v >= 5'd10);
    o = t ? 4'(v - 5'd10) : v[3:0];
    return {t, o};
  endfunction

  // Button bus: [3:0] candidates, [4] open, [5] close, [6] result.
  logic [NBTN-1:0] raw_bus;
  logic [NBTN-1:0] sync_p0;
  logic [NBTN-1:0] sync_p1;
  logic [NBTN-1:0] stable_p2;
  logic [NBTN-1:0] stable_d_p3;
  logic [NBTN-1:0] press_p3;
  logic [DB_W-1:0] db_cnt [NBTN];

  state_t     state_q;
  state_t     state_d;
  logic [4:0] cand_cnt [4];
  logic [4:0] total_q;
  logic [1:0] winner_q;
  logic [1:0] best_idx;
  logic [4:0] best_cnt;
  logic [1:0] vote_idx;
  logic [4:0] disp_val;
  logic       vote_ok;
  logic       enter_open;
  logic       lock;
  logic       open_p;
  logic       close_p;
  logic       result_p;
  logic [3:0] cand_p;

  assign raw_bus  = {btn_result, btn_close, btn_open, vote_btn};
  assign cand_p   = press_p3[3:0];
  assign open_p   = press_p3[4];
  assign close_p  = press_p3[5];
  assign result_p = press_p3[6];

  // ---- stage p0/p1: two-flop synchronizer
  // Bring raw buttons into the clock domain.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw_bus;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: debounce
  // Accept a new level only after it differs from the stable one for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      stable_p2 <= '0;
      for (int i = 0; i < NBTN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (sync_p1[i] != stable_p2[i]) begin
          if (db_cnt[i] == DB_MAX) begin
            stable_p2[i] <= sync_p1[i];
            db_cnt[i]    <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // ---- stage p3: press pulse
  // One-cycle pulse on each rising edge of the debounced level.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      stable_d_p3 <= '0;
      press_p3    <= '0;
    end else begin
      stable_d_p3 <= stable_p2;
      press_p3    <= stable_p2 & ~stable_d_p3;
    end
  end

  // Candidate index of the (single) pressed candidate.
  always_comb begin
    vote_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (cand_p[i]) vote_idx = 2'(i);
    end
  end

  assign vote_ok = (state_q == S_OPEN) && $onehot(cand_p) && (total_q < VOTE_CAP) && !lock;

  // Election state register.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; unlisted button/state combinations hold the state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (open_p)   state_d = S_OPEN;
      S_OPEN:   if (close_p)  state_d = S_CLOSED;
      S_CLOSED: if (result_p) state_d = S_WINNER;
      S_WINNER: if (open_p)   state_d = S_OPEN;
      default:                state_d = S_IDLE;
    endcase
  end

  assign enter_open = (state_q != S_OPEN) && (state_d == S_OPEN);

  // Tally: clear on every new election, count accepted votes otherwise.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      total_q <= '0;
      for (int i = 0; i < 4; i++) cand_cnt[i] <= '0;
    end else if (enter_open) begin
      total_q <= '0;
      for (int i = 0; i < 4; i++) cand_cnt[i] <= '0;
    end else if (vote_ok) begin
      total_q            <= total_q + 5'd1;
      cand_cnt[vote_idx] <= cand_cnt[vote_idx] + 5'd1;
    end
  end

  // Maximum search; strict compare keeps the lowest index on ties.
  always_comb begin
    best_idx = 2'd0;
    best_cnt = cand_cnt[0];
    for (int i = 1; i < 4; i++) begin
      if (cand_cnt[i] > best_cnt) begin
        best_idx = 2'(i);
        best_cnt = cand_cnt[i];
      end
    end
  end

  // Winner is captured on CLOSED -> WINNER and cleared when a new election opens.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)                                          winner_q <= 2'd0;
    else if (enter_open)                                winner_q <= 2'd0;
    else if (state_q == S_CLOSED && state_d == S_WINNER) winner_q <= best_idx;
  end

  // Value shown on the display for the current state.
  always_comb begin
    disp_val = 5'd0;
    case (state_q)
      S_OPEN, S_CLOSED: disp_val = total_q;
      S_WINNER:         disp_val = cand_cnt[winner_q];
      default:          disp_val = 5'd0;
    endcase
  end

  // Registered display digits, one cycle behind the counters/state.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) {tens, ones} <= 5'd0;
    else       {tens, ones} <= to_bcd(disp_val);
  end

  assign state  = state_q;
  assign winner = winner_q;

`ifdef EVM_VOTE_ACK_EN
  localparam int ACK_W = $clog2(ACK_CYCLES + 1);

  logic             ack_q;
  logic [ACK_W-1:0] ack_cnt;

  // Acknowledge pulse after each accepted vote; doubles as the candidate lockout.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      ack_q   <= 1'b0;
      ack_cnt <= '0;
    end else if (state_d != S_OPEN) begin
      ack_q   <= 1'b0;
      ack_cnt <= '0;
    end else if (vote_ok) begin
      ack_q   <= 1'b1;
      ack_cnt <= ACK_W'(ACK_CYCLES - 1);
    end else if (ack_q) begin
      if (ack_cnt == '0) ack_q <= 1'b0;
      else               ack_cnt <= ack_cnt - 1'b1;
    end
  end

  assign lock     = ack_q;
  assign vote_ack = ack_q;
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_evm_vote_controller.sv
// Self-checking bench for evm_vote_controller (DEBOUNCE_CYCLES=4, ACK_CYCLES=8).
// Define EVM_VOTE_ACK_EN on both files to exercise the vote_ack lockout.
`timescale 1ns/1ps

module tb_evm_vote_controller;

  localparam int DB  = 4;
  localparam int ACK = 8;
  localparam logic [2:0] OP_NONE   = 3'b000;
  localparam logic [2:0] OP_OPEN   = 3'b001;
  localparam logic [2:0] OP_CLOSE  = 3'b010;
  localparam logic [2:0] OP_RESULT = 3'b100;

  logic       clk_100MHz = 1'b0;
  logic       reset;
  logic       btn_open, btn_close, btn_result;
  logic [3:0] vote_btn;
  logic [1:0] state;
  logic       tens;
  logic [3:0] ones;
  logic [1:0] winner;
`ifdef EVM_VOTE_ACK_EN
  logic       vote_ack;
`endif

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q [$];
  logic [8:0] exp_v;
  wire  [8:0] obs = {state, tens, ones, winner};

  evm_vote_controller #(
    .DEBOUNCE_CYCLES(DB),
    .MAX_VOTES      (19),
    .ACK_CYCLES     (ACK)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .btn_open  (btn_open),
    .btn_close (btn_close),
    .btn_result(btn_result),
    .vote_btn  (vote_btn),
    .state     (state),
    .tens      (tens),
    .ones      (ones),
    .winner    (winner)
`ifdef EVM_VOTE_ACK_EN
    ,
    .vote_ack  (vote_ack)
`endif
  );

  always #5 clk_100MHz = ~clk_100MHz;

  function automatic logic [8:0] mk(input logic [1:0] s, input logic t, input logic [3:0] o,
                                    input logic [1:0] w);
    return {s, t, o, w};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  // Clean press: hold long enough to debounce and update the display, then release fully.
  task automatic press(input logic [2:0] ops, input logic [3:0] c);
    {btn_result, btn_close, btn_open} = ops;
    vote_btn = c;
    tick(DB + 6);
    {btn_result, btn_close, btn_open} = 3'b000;
    vote_btn = 4'b0000;
    tick(DB + 8);
  endtask

  task automatic test_reset();
    logic [3:0] cs [3] = '{4'b0011, 4'b0000, 4'b0000};
    logic [2:0] op [3] = '{OP_NONE, OP_CLOSE, OP_RESULT};
    reset = 1'b1;
    {btn_result, btn_close, btn_open} = 3'b000;
    vote_btn = 4'b0000;
    tick(3);
    exp_q.push_back(mk(2'b00, 1'b0, 4'd0, 2'b00));
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b", obs, exp_v);
    end
    reset = 1'b0;
    tick(4);
    for (int i = 0; i < 3; i++) begin
      press(op[i], cs[i]);
      exp_q.push_back(mk(2'b00, 1'b0, 4'd0, 2'b00));
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL idle_ignore%0d: got s=%b t=%b o=%0d w=%b expected s=%b t=%b o=%0d w=%b",
                 i, state, tens, ones, winner, exp_v[8:7], exp_v[6], exp_v[5:2], exp_v[1:0]);
      end
    end
  endtask

  task automatic test_basic_vote();
    logic [2:0] op [8] = '{OP_OPEN, OP_NONE, OP_NONE, OP_NONE, OP_NONE, OP_NONE, OP_CLOSE, OP_RESULT};
    logic [3:0] cs [8] = '{4'b0000, 4'b0010, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0000, 4'b0000};
    logic [8:0] ex [8] = '{9'b01_0_0000_00, 9'b01_0_0001_00, 9'b01_0_0010_00, 9'b01_0_0011_00,
                           9'b01_0_0100_00, 9'b01_0_0101_00, 9'b10_0_0101_00, 9'b11_0_0011_01};
    for (int i = 0; i < 8; i++) begin
      press(op[i], cs[i]);
      exp_q.push_back(ex[i]);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL basic_step%0d: got s=%b t=%b o=%0d w=%b expected s=%b t=%b o=%0d w=%b",
                 i, state, tens, ones, winner, exp_v[8:7], exp_v[6], exp_v[5:2], exp_v[1:0]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [2:0] op;
    logic [3:0] c;
    int         v;
    for (int i = 0; i < 28; i++) begin
      op = (i == 0) ? OP_OPEN : (i == 26) ? OP_CLOSE : (i == 27) ? OP_RESULT : OP_NONE;
      c  = (i >= 1 && i <= 25) ? 4'b1000 : 4'b0000;
      v  = (i > 19) ? 19 : i;
      press(op, c);
      if (i < 26)       exp_q.push_back(mk(2'b01, v >= 10, 4'(v >= 10 ? v - 10 : v), 2'b00));
      else if (i == 26) exp_q.push_back(mk(2'b10, 1'b1, 4'd9, 2'b00));
      else              exp_q.push_back(mk(2'b11, 1'b1, 4'd9, 2'b11));
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL saturate_step%0d: got s=%b t=%b o=%0d w=%b expected s=%b t=%b o=%0d w=%b",
                 i, state, tens, ones, winner, exp_v[8:7], exp_v[6], exp_v[5:2], exp_v[1:0]);
      end
    end
  endtask

  task automatic test_simultaneous_and_tie();
    logic [2:0] op [8] = '{OP_OPEN, OP_NONE, OP_NONE, OP_NONE, OP_NONE, OP_NONE, OP_CLOSE, OP_RESULT};
    logic [3:0] cs [8] = '{4'b0000, 4'b0101, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic [8:0] ex [8] = '{9'b01_0_0000_00, 9'b01_0_0000_00, 9'b01_0_0001_00, 9'b01_0_0010_00,
                           9'b01_0_0011_00, 9'b01_0_0100_00, 9'b10_0_0100_00, 9'b11_0_0010_00};
    for (int i = 0; i < 8; i++) begin
      press(op[i], cs[i]);
      exp_q.push_back(ex[i]);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL simul_tie_step%0d: got s=%b t=%b o=%0d w=%b expected s=%b t=%b o=%0d w=%b",
                 i, state, tens, ones, winner, exp_v[8:7], exp_v[6], exp_v[5:2], exp_v[1:0]);
      end
    end
  endtask

  task automatic test_bounce_and_async_reset();
    press(OP_OPEN, 4'b0000);
    exp_q.push_back(mk(2'b01, 1'b0, 4'd0, 2'b00));
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL bounce_open: got %b expected %b", obs, exp_v);
    end
    // Toggle c1 every 2 cycles for 20 cycles, then hold it high.
    for (int i = 0; i < 10; i++) begin
      vote_btn = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      tick(2);
    end
    vote_btn = 4'b0010;
    tick(DB + 6);
    vote_btn = 4'b0000;
    tick(DB + 8);
    exp_q.push_back(mk(2'b01, 1'b0, 4'd1, 2'b00));
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL bounce_one_vote: got ones=%0d total-state %b expected %b", ones, obs, exp_v);
    end
    // Reset while c2 is part-way through its debounce window.
    vote_btn = 4'b0100;
    tick(3);
    reset = 1'b1;
    #1;
    exp_q.push_back(mk(2'b00, 1'b0, 4'd0, 2'b00));
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_mid_debounce: got %b expected %b", obs, exp_v);
    end
    tick(2);
    reset = 1'b0;
    tick(DB + 8);
    exp_q.push_back(mk(2'b00, 1'b0, 4'd0, 2'b00));
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL after_reset_idle: got %b expected %b", obs, exp_v);
    end
    vote_btn = 4'b0000;
    tick(DB + 8);
  endtask

`ifdef EVM_VOTE_ACK_EN
  task automatic test_vote_ack();
    int high_cnt;
    press(OP_OPEN, 4'b0000);
    // c0 accepted; c1 pulse lands while vote_ack is still high and must be rejected.
    high_cnt = 0;
    vote_btn = 4'b0001;
    for (int i = 0; i < 40; i++) begin
      if (i == 5)  vote_btn = 4'b0011;
      if (i == 8)  vote_btn = 4'b0010;
      if (i == 20) vote_btn = 4'b0000;
      tick(1);
      if (vote_ack === 1'b1) high_cnt++;
    end
    checks++;
    if (high_cnt != ACK) begin
      errors++;
      $display("FAIL ack_length: got %0d cycles high expected %0d", high_cnt, ACK);
    end
    exp_q.push_back(mk(2'b01, 1'b0, 4'd1, 2'b00));
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL ack_lockout: got %b expected %b", obs, exp_v);
    end
    press(OP_NONE, 4'b0100);
    exp_q.push_back(mk(2'b01, 1'b0, 4'd2, 2'b00));
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL ack_after_drop: got %b expected %b", obs, exp_v);
    end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    btn_open   = 1'b0;
    btn_close  = 1'b0;
    btn_result = 1'b0;
    vote_btn   = 4'b0000;
    test_reset();
    test_basic_vote();
    test_saturate();
    test_simultaneous_and_tie();
    test_bounce_and_async_reset();
`ifdef EVM_VOTE_ACK_EN
    test_vote_ack();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
